// File: rtl/fetch_queue_if.sv
// fetch_queue_if: enqueue/dequeue bus between the instruction fetch unit and
// the dual-issue decode stage.
//   master modport (fetch/decode side): drives in_cnt, in_pc, in_inst0/1,
//     deq_cnt; observes in_ready and the two head lanes.
//   slave modport (fetch_queue): the reverse.
//   in_cnt / deq_cnt : 0..2 instructions offered / consumed this cycle
//   in_pc            : PC of lane 0 (lane 1 is in_pc + 4)
//   in_ready         : at least two free entries
//   out_valid        : bit0 = head valid, bit1 = head+1 valid
//   out_pc0/1, out_inst0/1 : head and head+1 entries, zero when not valid
interface fetch_queue_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [1:0]    in_cnt;
  logic [AW-1:0] in_pc;
  logic [DW-1:0] in_inst0;
  logic [DW-1:0] in_inst1;
  logic          in_ready;
  logic [1:0]    deq_cnt;
  logic [1:0]    out_valid;
  logic [AW-1:0] out_pc0;
  logic [AW-1:0] out_pc1;
  logic [DW-1:0] out_inst0;
  logic [DW-1:0] out_inst1;

  modport master (
    output in_cnt, in_pc, in_inst0, in_inst1, deq_cnt,
    input  in_ready, out_valid, out_pc0, out_pc1, out_inst0, out_inst1
  );

  modport slave (
    input  in_cnt, in_pc, in_inst0, in_inst1, deq_cnt,
    output in_ready, out_valid, out_pc0, out_pc1, out_inst0, out_inst1
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry two-lane circular instruction queue between
// instruction memory and decode. Up to two instructions enter and up to two
// leave per cycle; flush empties the queue in one cycle.
// Ports:
//   clk       : clock, all state updates on the rising edge
//   reset     : asynchronous active-high reset of pointers, count and flags
//   flush     : discard all entries (taken branch / jump); beats enq/deq
//   bus       : fetch_queue_if.slave enqueue/dequeue bus
//   count     : current occupancy 0..DEPTH
//   overflow  : sticky, enqueue offered while in_ready was low
//   underflow : sticky, deq_cnt exceeded the available head entries
// DEPTH must be a power of two, at least 4, so pointers wrap naturally.
module fetch_queue #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  fetch_queue_if.slave  bus,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] pc_mem   [DEPTH];
  logic [DW-1:0] inst_mem [DEPTH];

  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW-1:0] wp_1;
  logic [PW-1:0] rp_1;

  logic [1:0]    in_n;
  logic [1:0]    deq_n;
  logic [1:0]    avail;
  logic [1:0]    deq_e;
  logic [1:0]    enq_n;
  logic          enq_req;
  logic          enq_ok;
  logic          ready;
  logic          vld0;
  logic          vld1;

  // Request decode; a lane count of 3 is clamped to 2.
  always_comb begin
    in_n    = (bus.in_cnt  == 2'd3) ? 2'd2 : bus.in_cnt;
    deq_n   = (bus.deq_cnt == 2'd3) ? 2'd2 : bus.deq_cnt;
    wp_1    = wp + PW'(1);
    rp_1    = rp + PW'(1);
    // Conservative pair-based readiness: a single free slot is not enough,
    // so the producer never has to split a fetch pair.
    ready   = (count <= CW'(DEPTH - 2));
    vld0    = (count != '0);
    vld1    = (count >= CW'(2));
    avail   = vld1 ? 2'd2 : {1'b0, vld0};
    deq_e   = (deq_n < avail) ? deq_n : avail;
    enq_req = (in_n != 2'd0);
    enq_ok  = enq_req && ready && !flush;
    enq_n   = enq_ok ? in_n : 2'd0;
  end

  // Control state: pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      // Flush outranks enq/deq; the sticky flags survive it.
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (enq_req && !ready) begin
        overflow <= 1'b1;
      end
      if (deq_n > deq_e) begin
        underflow <= 1'b1;
      end
      wp    <= wp + PW'(enq_n);
      rp    <= rp + PW'(deq_e);
      count <= count + CW'(enq_n) - CW'(deq_e);
    end
  end

  // Storage: data only, no reset. Stale entries are masked on the outputs.
  always_ff @(posedge clk) begin
    if (enq_ok) begin
      pc_mem[wp]   <= bus.in_pc;
      inst_mem[wp] <= bus.in_inst0;
      if (in_n == 2'd2) begin
        pc_mem[wp_1]   <= bus.in_pc + AW'(4);
        inst_mem[wp_1] <= bus.in_inst1;
      end
    end
  end

  // Outputs depend only on registered state, so there is no in-to-out path.
  assign bus.in_ready  = ready;
  assign bus.out_valid = {vld1, vld0};
  assign bus.out_pc0   = vld0 ? pc_mem[rp]     : '0;
  assign bus.out_inst0 = vld0 ? inst_mem[rp]   : '0;
  assign bus.out_pc1   = vld1 ? pc_mem[rp_1]   : '0;
  assign bus.out_inst1 = vld1 ? inst_mem[rp_1] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed test of fetch_queue (DEPTH = 8) with hand-computed
// expectations: reset, fill/overflow, wrap-around streaming, mixed rates,
// pair-granular readiness, flush, underflow and asynchronous reset.
module tb_fetch_queue;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue_if #(.DW(32), .AW(32)) qif ();

  fetch_queue #(.DW(32), .AW(32), .DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (qif),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    qif.in_cnt   = 2'd0;
    qif.in_pc    = '0;
    qif.in_inst0 = '0;
    qif.in_inst1 = '0;
    qif.deq_cnt  = 2'd0;
    flush        = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  // Offer n instructions at pc (inst = pc, pc+4 unless given) and dequeue d.
  task automatic cyc(input logic [1:0] n, input logic [31:0] pc,
                     input logic [31:0] i0, input logic [31:0] i1,
                     input logic [1:0] d);
    qif.in_cnt   = n;
    qif.in_pc    = pc;
    qif.in_inst0 = i0;
    qif.in_inst1 = i1;
    qif.deq_cnt  = d;
    step();
  endtask

  logic [31:0] pc;
  logic [31:0] head;

  initial begin
    reset = 1'b1;
    idle();
    #12;
    check("rst_count",     count,          0);
    check("rst_valid",     qif.out_valid,  0);
    check("rst_ready",     qif.in_ready,   1);
    check("rst_overflow",  overflow,       0);
    check("rst_underflow", underflow,      0);
    check("rst_pc0",       qif.out_pc0,    0);
    reset = 1'b0;

    // First pair visible one cycle later.
    cyc(2'd2, 32'h100, 32'hA, 32'hB, 2'd0);
    check("pair_valid", qif.out_valid, 2'b11);
    check("pair_pc0",   qif.out_pc0,   32'h100);
    check("pair_pc1",   qif.out_pc1,   32'h104);
    check("pair_inst0", qif.out_inst0, 32'hA);
    check("pair_inst1", qif.out_inst1, 32'hB);
    check("pair_count", count,         2);

    // Fill to DEPTH.
    cyc(2'd2, 32'h108, 32'h108, 32'h10C, 2'd0);
    cyc(2'd2, 32'h110, 32'h110, 32'h114, 2'd0);
    check("cnt6_count", count,        6);
    check("cnt6_ready", qif.in_ready, 1);
    cyc(2'd2, 32'h118, 32'h118, 32'h11C, 2'd0);
    check("full_count", count,        8);
    check("full_ready", qif.in_ready, 0);
    check("full_ovf",   overflow,     0);

    // Offer while full: rejected, overflow sticks, contents intact.
    cyc(2'd2, 32'h200, 32'h200, 32'h204, 2'd0);
    check("ovf_flag",  overflow,      1);
    check("ovf_count", count,         8);
    check("ovf_pc0",   qif.out_pc0,   32'h100);
    check("ovf_inst1", qif.out_inst1, 32'hB);

    cyc(2'd0, 32'h0, 32'h0, 32'h0, 2'd2);
    check("deq2_count", count,         6);
    check("deq2_pc0",   qif.out_pc0,   32'h108);
    check("deq2_inst0", qif.out_inst0, 32'h108);

    // Stream through several wraps: head must step by exactly 8 each cycle.
    for (int k = 0; k < 20; k++) begin
      pc = 32'h120 + 32'(8 * k);
      cyc(2'd2, pc, pc, pc + 32'd4, 2'd2);
      head = 32'h110 + 32'(8 * k);
      check("wrap_pc0",   qif.out_pc0,   head);
      check("wrap_pc1",   qif.out_pc1,   head + 32'd4);
      check("wrap_inst1", qif.out_inst1, head + 32'd4);
      check("wrap_count", count,         6);
    end

    // Mixed rates.
    cyc(2'd0, 32'h0, 32'h0, 32'h0, 2'd2);
    check("mix_a_count", count,       4);
    check("mix_a_pc0",   qif.out_pc0, 32'h1B0);
    cyc(2'd0, 32'h0, 32'h0, 32'h0, 2'd1);
    check("mix_b_count", count,       3);
    check("mix_b_pc0",   qif.out_pc0, 32'h1B4);
    cyc(2'd2, 32'h300, 32'h300, 32'h304, 2'd1);
    check("mix_c_count", count,       4);
    check("mix_c_pc0",   qif.out_pc0, 32'h1B8);
    check("mix_c_pc1",   qif.out_pc1, 32'h1BC);

    // Pair-granular readiness at DEPTH-1.
    cyc(2'd2, 32'h308, 32'h308, 32'h30C, 2'd0);
    cyc(2'd1, 32'h310, 32'h310, 32'h0, 2'd0);
    check("c7_count", count,        7);
    check("c7_ready", qif.in_ready, 0);
    cyc(2'd1, 32'h318, 32'h318, 32'h0, 2'd0);
    check("c7_refused", count, 7);
    cyc(2'd0, 32'h0, 32'h0, 32'h0, 2'd2);
    check("c7_deq_pc0",   qif.out_pc0, 32'h300);
    check("c7_deq_count", count,       5);

    // Clear sticky flags with a mid-cycle reset.
    #3 reset = 1'b1;
    #2 reset = 1'b0;
    step();
    check("rst2_ovf",   overflow, 0);
    check("rst2_count", count,    0);

    // Flush beats a concurrent pair enqueue and dequeue.
    cyc(2'd2, 32'h600, 32'h600, 32'h604, 2'd0);
    cyc(2'd2, 32'h608, 32'h608, 32'h60C, 2'd0);
    cyc(2'd2, 32'h610, 32'h610, 32'h614, 2'd0);
    check("pre_flush_count", count, 6);
    flush = 1'b1;
    cyc(2'd2, 32'h700, 32'h700, 32'h704, 2'd2);
    check("flush_count", count,         0);
    check("flush_valid", qif.out_valid, 0);
    check("flush_ready", qif.in_ready,  1);
    check("flush_ovf",   overflow,      0);
    check("flush_pc0",   qif.out_pc0,   0);

    // Single entry: lane 1 masked; then over-dequeue.
    cyc(2'd1, 32'h800, 32'h55, 32'h66, 2'd0);
    check("one_valid", qif.out_valid, 2'b01);
    check("one_pc0",   qif.out_pc0,   32'h800);
    check("one_inst0", qif.out_inst0, 32'h55);
    check("one_pc1",   qif.out_pc1,   0);
    check("one_inst1", qif.out_inst1, 0);
    cyc(2'd0, 32'h0, 32'h0, 32'h0, 2'd2);
    check("udf_count", count,     0);
    check("udf_flag",  underflow, 1);
    check("udf_udf_ovf", overflow, 0);

    // Empty after flush lands at rp=0, then lane wrap continues normally.
    cyc(2'd2, 32'h900, 32'h900, 32'h904, 2'd0);
    check("pre_arst_count", count, 2);

    // Asynchronous reset between edges.
    #3 reset = 1'b1;
    #1;
    check("arst_count", count,         0);
    check("arst_udf",   underflow,     0);
    check("arst_valid", qif.out_valid, 0);
    check("arst_pc0",   qif.out_pc0,   0);
    #2 reset = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised two-lane instruction fetch queue that sits between instruction memory and the decode stage of the dual-issue pipeline. It replaces the single IF/ID instruction register with a DEPTH-entry circular buffer. Fetch can run ahead of decode, decode can consume zero, one or two instructions per cycle, and a branch or jump flush empties the queue in one cycle. Each entry holds an instruction word and its PC.

## Interface
Parameters:
- DW, 32, instruction word width
- AW, 32, PC width
- DEPTH, 8, entry count; power of two, minimum 4
- CW, $clog2(DEPTH)+1, occupancy counter width (derived; not overridden)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all state
- flush  input  1  discard all entries (taken branch or jump)
- in_cnt  input  2  instructions offered this cycle, 0..2; value 3 is treated as 2
- in_pc  input  AW  PC of lane 0; lane 1 PC = in_pc + 4 (mod 2^AW)
- in_inst0  input  DW  lane 0 instruction
- in_inst1  input  DW  lane 1 instruction
- in_ready  output  1  high when free entries >= 2
- deq_cnt  input  2  instructions consumed this cycle, 0..2; value 3 is treated as 2
- out_valid  output  2  bit0 = head entry valid; bit1 = head+1 entry valid
- out_pc0, out_pc1  output  AW  PCs of head and head+1
- out_inst0, out_inst1  output  DW  instructions of head and head+1
- count  output  CW  current occupancy, 0..DEPTH
- overflow  output  1  sticky; enqueue was attempted while in_ready was low
- underflow  output  1  sticky; deq_cnt exceeded the available entries

## Operation
- Storage: DEPTH entries of {AW pc, DW inst}. Registers: write pointer wp, read pointer rp, and count. wp and rp are log2(DEPTH) bits and wrap modulo DEPTH.
- Enqueue:
  - Enqueue happens when in_cnt > 0, in_ready = 1 and flush = 0.
  - Lane 0 is written at wp. If in_cnt = 2, lane 1 is written at wp+1.
  - wp advances by in_cnt.
- Rejected enqueue: if in_cnt > 0 and in_ready = 0, nothing is written and overflow is set.
- Dequeue:
  - Effective count e = min(deq_cnt, popcount(out_valid)).
  - rp advances by e.
  - If deq_cnt > e, underflow is set and only e entries are removed.
- Concurrent enqueue and dequeue: count_next = count + enq_n - e. Both are permitted in the same cycle. in_ready uses the pre-update count.
- Flush:
  - Flush has priority over enqueue and dequeue in the same cycle.
  - wp, rp and count become 0.
  - Storage contents are left unchanged but are unreachable.
  - overflow and underflow are not cleared by flush.
- Output masking:
  - out_valid[0] = (count >= 1); out_valid[1] = (count >= 2).
  - When the corresponding valid bit is 0, out_pc and out_inst are driven to 0.
  - Lane 1 outputs come from entry rp+1 with wrap.
- No state machine beyond the pointers and counter. There are two status states, EMPTY (count = 0) and NON_EMPTY. FULL is count = DEPTH.

## Timing
- Reset values: wp = rp = count = 0; out_valid = 2'b00; all out_pc and out_inst = 0; in_ready = 1; overflow = underflow = 0.
- Reset during operation: all entries are lost immediately (asynchronous). Outputs take their reset values without waiting for a clock edge.
- Outputs are combinational from registered state. There is no path from input to output within the same cycle; in_ready does not depend on in_cnt or deq_cnt.
- Enqueue-to-visible latency: 1 cycle. An instruction enqueued at edge N appears on out_* after edge N.
- Dequeue takes effect at the clock edge. The next head entries are visible after that edge.
- Boundaries:
  - count = DEPTH-1: in_ready = 0. A single-instruction offer is refused, because the decision is conservative and based on lane pairs.
  - Empty with deq_cnt = 1: underflow is set and the state is otherwise unchanged.
  - Pointer wrap from DEPTH-1 to 0 must preserve FIFO order, including for the lane 1 read and write at DEPTH-1 → 0.
  - Flush together with in_cnt = 2: the queue is empty after the edge and the offered pair is dropped. overflow is not set.

## Test plan
- Reset, then in_cnt=2 with in_pc=0x100, inst0=0xA, inst1=0xB, for one cycle → next cycle: out_valid=2'b11, out_pc0=0x100, out_pc1=0x104, out_inst0=0xA, out_inst1=0xB, count=2.
- Fill the queue: DEPTH=8, four pair enqueues with no dequeue → count=8, in_ready=0. A fifth pair → overflow=1 and count stays 8.
- Wrap-around: continuous in_cnt=2 with deq_cnt=2 for 20 cycles, PCs stepping by 8 → out_pc0 sequence is monotonic with step 8 and there are no gaps or duplicates across the DEPTH boundary.
- Mixed rates: count=3, deq_cnt=1 and in_cnt=2 in the same cycle → count=4 and the head advances by one.
- Flush: count=6, flush=1 with in_cnt=2 and deq_cnt=2 → count=0, out_valid=0, in_ready=1, overflow=0.
- Underflow and asynchronous reset:
  - count=1, deq_cnt=2 → count=0, underflow=1.
  - Assert reset between clock edges → underflow=0 and count=0 immediately.
